// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W).
// It handles:
//   - M/W operand forwarding into the E stage,
//   - use-qualified load-use stalling,
//   - a multi-cycle MDU stall FSM,
//   - trap flush,
//   - branch-over-load-stall priority.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
// Otherwise stall_cnt and flush_cnt are tied to zero.
module hazard_unit_mc #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MDU_LAT = 4,
   parameter int unsigned CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1d,
   input  logic [REG_AW-1:0] rs2d,
   input  logic              UseRs1D,
   input  logic              UseRs2D,
   input  logic [REG_AW-1:0] rs1e,
   input  logic [REG_AW-1:0] rs2e,
   input  logic [REG_AW-1:0] rde,
   input  logic [REG_AW-1:0] rdm,
   input  logic [REG_AW-1:0] rdw,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic [1:0]        ResultSrcE,
   input  logic [1:0]        ResultSrcM,
   input  logic              PCsrc,
   input  logic              MduStartE,
   input  logic              TrapE,
   output logic [1:0]        forwardae,
   output logic [1:0]        forwardbe,
   output logic              stallf,
   output logic              stalld,
   output logic              stalle,
   output logic              flushd,
   output logic              flushe,
   output logic              flushm,
   output logic              mdu_busy,
   output logic              mdu_done,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_W    = 2'b01;
   localparam logic [1:0] FWD_MALU = 2'b10;
   localparam logic [1:0] FWD_MPC  = 2'b11;

   // Elaboration-time sanity of the MDU latency and counter width
   if (MDU_LAT < 2 || MDU_LAT > 16) begin : g_lat_chk
      $error("hazard_unit_mc: MDU_LAT must be in 2..16");
   end
   if ((MDU_LAT - 2) >= (2 ** CNT_W)) begin : g_cnt_chk
      $error("hazard_unit_mc: CNT_W too narrow for MDU_LAT-2");
   end

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } mdu_state_t;

   mdu_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_ld_stall;
   logic              w_mdu_stall;
   logic              w_mdu_last;
   logic [1:0]        w_fwd_a;
   logic [1:0]        w_fwd_b;

   // Forward select for one E-stage source; a load in M never forwards from M
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] rd_m,
      input logic              we_m,
      input logic [1:0]        src_m,
      input logic [REG_AW-1:0] rd_w,
      input logic              we_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (rs != '0 && we_m && rs == rd_m && src_m != RES_LOAD) begin
         sel = src_m[1] ? FWD_MPC : FWD_MALU;
      end else if (rs != '0 && we_w && rs == rd_w) begin
         sel = FWD_W;
      end
      return sel;
   endfunction

   // Forwarding mux selects for both E-stage operands
   always_comb begin
      w_fwd_a = fwd_sel(rs1e, rdm, RegWriteM, ResultSrcM, rdw, RegWriteW);
      w_fwd_b = fwd_sel(rs2e, rdm, RegWriteM, ResultSrcM, rdw, RegWriteW);
   end

   // Load-use hazard, only when the D instruction really reads the register
   always_comb begin
      w_ld_stall = (ResultSrcE == RES_LOAD) && (rde != '0) &&
                   ((UseRs1D && rs1d == rde) || (UseRs2D && rs2d == rde));
   end

   // MDU stall while the op occupies E; last occupancy cycle releases the pipe
   always_comb begin
      w_mdu_last  = (r_state == S_BUSY) && (r_cnt == '0);
      w_mdu_stall = ((r_state == S_IDLE) && MduStartE) ||
                    ((r_state == S_BUSY) && (r_cnt != '0));
   end

   // MDU occupancy FSM; trap or reset aborts any in-flight op
   always_ff @(posedge clk) begin
      if (rst || TrapE) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (MduStartE) begin
                  r_state <= S_BUSY;
                  r_cnt   <= CNT_W'(MDU_LAT - 2);
               end
            end
            S_BUSY: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Prioritised stall/flush resolution: reset/trap > MDU > redirect > load-use
   always_comb begin
      stallf    = 1'b0;
      stalld    = 1'b0;
      stalle    = 1'b0;
      flushd    = 1'b0;
      flushe    = 1'b0;
      flushm    = 1'b0;
      forwardae = w_fwd_a;
      forwardbe = w_fwd_b;
      mdu_busy  = (r_state == S_BUSY);
      mdu_done  = w_mdu_last && !TrapE;
      if (rst) begin
         flushd    = 1'b1;
         flushe    = 1'b1;
         flushm    = 1'b1;
         forwardae = FWD_RF;
         forwardbe = FWD_RF;
         mdu_busy  = 1'b0;
         mdu_done  = 1'b0;
      end else if (TrapE) begin
         flushd = 1'b1;
         flushe = 1'b1;
         flushm = 1'b1;
      end else if (w_mdu_stall) begin
         stallf = 1'b1;
         stalld = 1'b1;
         stalle = 1'b1;
         flushm = 1'b1;
      end else if (PCsrc) begin
         flushd = 1'b1;
         flushe = 1'b1;
      end else if (w_ld_stall) begin
         stallf = 1'b1;
         stalld = 1'b1;
         flushe = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   // Performance counters: fetch-stall cycles and any-flush cycles, wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stallf) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (flushd || flushe || flushm) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model.
module tb_hazard_unit_mc;

   localparam int unsigned AW  = 5;
   localparam int unsigned LAT = 4;

   logic          clk;
   logic          rst;
   logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic          UseRs1D, UseRs2D, RegWriteM, RegWriteW;
   logic [1:0]    ResultSrcE, ResultSrcM;
   logic          PCsrc, MduStartE, TrapE;
   logic [1:0]    forwardae, forwardbe;
   logic          stallf, stalld, stalle, flushd, flushe, flushm;
   logic          mdu_busy, mdu_done;
   logic [31:0]   stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   hazard_unit_mc #(.REG_AW(AW), .MDU_LAT(LAT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .rs1d(rs1d), .rs2d(rs2d), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
      .rs1e(rs1e), .rs2e(rs2e), .rde(rde), .rdm(rdm), .rdw(rdw),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
      .PCsrc(PCsrc), .MduStartE(MduStartE), .TrapE(TrapE),
      .forwardae(forwardae), .forwardbe(forwardbe),
      .stallf(stallf), .stalld(stalld), .stalle(stalle),
      .flushd(flushd), .flushe(flushe), .flushm(flushm),
      .mdu_busy(mdu_busy), .mdu_done(mdu_done),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A load in M whose destination an E source reads must never be presented
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(RegWriteM && ResultSrcM == 2'b01 && rdm != '0 &&
                   (rdm == rs1e || rdm == rs2e)))
            else $error("illegal load-in-M forwarding case presented");
      end
   end

   task automatic set_idle();
      rst = 1'b0;
      rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0;
      UseRs1D = 1'b0; UseRs2D = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      ResultSrcE = 2'b00; ResultSrcM = 2'b00;
      PCsrc = 1'b0; MduStartE = 1'b0; TrapE = 1'b0;
   endtask

   // Leaves the bench at a falling edge with reset released and state cleared
   task automatic do_reset();
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      set_idle();
      rst = 1'b1; MduStartE = 1'b1; PCsrc = 1'b1;
      rs1e = 5'd3; rdm = 5'd3; RegWriteM = 1'b1;
      #1;
      checks++;
      if ({flushd, flushe, flushm, stallf, stalld, stalle} !== 6'b111000) begin
         errors++;
         $display("FAIL reset_ctl: got %b expected 111000",
                  {flushd, flushe, flushm, stallf, stalld, stalle});
      end
      checks++;
      if ({forwardae, forwardbe, mdu_busy, mdu_done} !== 6'b000000) begin
         errors++;
         $display("FAIL reset_fwd_mdu: got %b expected 000000",
                  {forwardae, forwardbe, mdu_busy, mdu_done});
      end
      @(negedge clk);
      checks++;
      if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
      end
      set_idle();
      #1;
      checks++;
      if ({flushd, flushe, flushm, stallf, mdu_busy, mdu_done} !== 6'b000000) begin
         errors++;
         $display("FAIL reset_release: got %b expected 000000",
                  {flushd, flushe, flushm, stallf, mdu_busy, mdu_done});
      end
   endtask

   task automatic test_forwarding();
      do_reset();
      rs1e = 5'd5; rs2e = 5'd5; rdm = 5'd5; RegWriteM = 1'b1; ResultSrcM = 2'b00;
      rdw = 5'd5; RegWriteW = 1'b1;
      #1;
      checks++;
      if ({forwardae, forwardbe} !== 4'b1010) begin
         errors++;
         $display("FAIL fwd_m_alu: got %b expected 1010", {forwardae, forwardbe});
      end
      ResultSrcM = 2'b10;
      #1;
      checks++;
      if ({forwardae, forwardbe} !== 4'b1111) begin
         errors++;
         $display("FAIL fwd_m_pc4: got %b expected 1111", {forwardae, forwardbe});
      end
      rs1e = 5'd0;
      #1;
      checks++;
      if ({forwardae, forwardbe} !== 4'b0011) begin
         errors++;
         $display("FAIL fwd_x0: got %b expected 0011", {forwardae, forwardbe});
      end
      rs1e = 5'd5; RegWriteM = 1'b0;
      #1;
      checks++;
      if ({forwardae, forwardbe} !== 4'b0101) begin
         errors++;
         $display("FAIL fwd_w: got %b expected 0101", {forwardae, forwardbe});
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_load_use();
      do_reset();
      ResultSrcE = 2'b01; rde = 5'd7; rs2d = 5'd7; UseRs2D = 1'b1;
      #1;
      checks++;
      if ({stallf, stalld, flushe, flushd, stalle, flushm} !== 6'b111000) begin
         errors++;
         $display("FAIL ld_use: got %b expected 111000",
                  {stallf, stalld, flushe, flushd, stalle, flushm});
      end
      UseRs2D = 1'b0;
      #1;
      checks++;
      if ({stallf, stalld, flushe} !== 3'b000) begin
         errors++;
         $display("FAIL ld_unused: got %b expected 000", {stallf, stalld, flushe});
      end
      rde = 5'd0; rs1d = 5'd0; UseRs1D = 1'b1;
      #1;
      checks++;
      if ({stallf, stalld, flushe} !== 3'b000) begin
         errors++;
         $display("FAIL ld_x0: got %b expected 000", {stallf, stalld, flushe});
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_branch_priority();
      do_reset();
      ResultSrcE = 2'b01; rde = 5'd9; rs1d = 5'd9; UseRs1D = 1'b1; PCsrc = 1'b1;
      #1;
      checks++;
      if ({flushd, flushe, stallf, stalld} !== 4'b1100) begin
         errors++;
         $display("FAIL br_over_ld: got %b expected 1100",
                  {flushd, flushe, stallf, stalld});
      end
      @(negedge clk);
      set_idle();
   endtask

   task automatic test_mdu_sequence();
      logic [4:0] exp_v;
      do_reset();
      for (int c = 0; c <= int'(LAT); c++) begin
         MduStartE = (c < int'(LAT));
         PCsrc     = 1'b1;
         #1;
         // stallf, stalle, flushm, mdu_busy, mdu_done
         exp_v = {(c <= int'(LAT) - 2), (c <= int'(LAT) - 2), (c <= int'(LAT) - 2),
                  (c >= 1 && c <= int'(LAT) - 1), (c == int'(LAT) - 1)};
         checks++;
         if ({stallf, stalle, flushm, mdu_busy, mdu_done} !== exp_v) begin
            errors++;
            $display("FAIL mdu_cycle%0d: got %b expected %b", c,
                     {stallf, stalle, flushm, mdu_busy, mdu_done}, exp_v);
         end
         @(negedge clk);
      end
      set_idle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      MduStartE = 1'b1;
      for (int c = 0; c < int'(LAT); c++) @(negedge clk);
      #1;
      checks++;
      if ({stallf, mdu_busy, mdu_done} !== 3'b100) begin
         errors++;
         $display("FAIL b2b_restart: got %b expected 100", {stallf, mdu_busy, mdu_done});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({stallf, mdu_busy} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_busy: got %b expected 11", {stallf, mdu_busy});
      end
      set_idle();
      TrapE = 1'b1;
      @(negedge clk);
      set_idle();
   endtask

   // Abort an op with cnt==1 (two cycles after start) by trap (0) or reset (1)
   task automatic test_abort();
      for (int k = 0; k < 2; k++) begin
         do_reset();
         MduStartE = 1'b1;
         @(negedge clk);
         @(negedge clk);
         if (k == 0) TrapE = 1'b1; else rst = 1'b1;
         #1;
         checks++;
         if ({flushd, flushe, flushm, stallf, stalld, stalle, mdu_done} !== 7'b1110000) begin
            errors++;
            $display("FAIL abort%0d_now: got %b expected 1110000", k,
                     {flushd, flushe, flushm, stallf, stalld, stalle, mdu_done});
         end
         @(negedge clk);
         TrapE = 1'b0; rst = 1'b0; MduStartE = 1'b0;
         #1;
         checks++;
         if ({mdu_busy, mdu_done, stallf} !== 3'b000) begin
            errors++;
            $display("FAIL abort%0d_next: got %b expected 000", k,
                     {mdu_busy, mdu_done, stallf});
         end
         @(negedge clk);
         #1;
         checks++;
         if ({mdu_busy, mdu_done} !== 2'b00) begin
            errors++;
            $display("FAIL abort%0d_after: got %b expected 00", k, {mdu_busy, mdu_done});
         end
      end
      set_idle();
   endtask

   task automatic test_perf();
      logic [31:0] exp_s, exp_f;
      do_reset();
      ResultSrcE = 2'b01; rde = 5'd4; rs2d = 5'd4; UseRs2D = 1'b1;
      for (int c = 0; c < 3; c++) @(negedge clk);
      set_idle();
      PCsrc = 1'b1;
      for (int c = 0; c < 2; c++) @(negedge clk);
      set_idle();
      #1;
`ifdef HAZARD_PERF_EN
      exp_s = 32'd3; exp_f = 32'd5;
`else
      exp_s = 32'd0; exp_f = 32'd0;
`endif
      checks++;
      if (stall_cnt !== exp_s || flush_cnt !== exp_f) begin
         errors++;
         $display("FAIL perf_cnt: got %0d/%0d expected %0d/%0d",
                  stall_cnt, flush_cnt, exp_s, exp_f);
      end
   endtask

   // Reference forwarding choice for one E-stage source
   function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
      if (rs != 0 && RegWriteM && rs == rdm && ResultSrcM != 2'b01)
         return (ResultSrcM == 2'b10 || ResultSrcM == 2'b11) ? 2'b11 : 2'b10;
      if (rs != 0 && RegWriteW && rs == rdw) return 2'b01;
      return 2'b00;
   endfunction

   task automatic test_random();
      int          elapsed;   // cycles the current MDU op has spent in E; 0 = none
      logic [31:0] m_stall, m_flush;
      logic        ld, mstall, mlast;
      logic [11:0] exp_v, got_v;
      logic [5:0]  ctl;
      do_reset();
      elapsed = 0; m_stall = 0; m_flush = 0;
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 59) == 0);
         TrapE      = ($urandom_range(0, 24) == 0);
         MduStartE  = ($urandom_range(0, 4) == 0);
         PCsrc      = ($urandom_range(0, 4) == 0);
         rs1d = AW'($urandom_range(0, 7)); rs2d = AW'($urandom_range(0, 7));
         rs1e = AW'($urandom_range(0, 7)); rs2e = AW'($urandom_range(0, 7));
         rde  = AW'($urandom_range(0, 7)); rdm  = AW'($urandom_range(0, 7));
         rdw  = AW'($urandom_range(0, 7));
         UseRs1D = 1'($urandom); UseRs2D = 1'($urandom);
         RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         ResultSrcE = 2'($urandom); ResultSrcM = 2'($urandom);
         if (ResultSrcM == 2'b01 && RegWriteM && rdm != 0 && (rdm == rs1e || rdm == rs2e))
            ResultSrcM = 2'b00;
         #1;
         ld = (ResultSrcE == 2'b01) && rde != 0 &&
              ((UseRs1D && rs1d == rde) || (UseRs2D && rs2d == rde));
         mstall = (elapsed == 0 && MduStartE) || (elapsed >= 1 && elapsed <= int'(LAT) - 2);
         mlast  = (elapsed == int'(LAT) - 1);
         // ctl = {stallf, stalld, stalle, flushd, flushe, flushm}
         if (rst || TrapE) ctl = 6'b000111;
         else if (mstall)  ctl = 6'b111001;
         else if (PCsrc)   ctl = 6'b000110;
         else if (ld)      ctl = 6'b110010;
         else              ctl = 6'b000000;
         exp_v = {rst ? 2'b00 : ref_fwd(rs1e), rst ? 2'b00 : ref_fwd(rs2e), ctl,
                  !rst && elapsed != 0, !rst && !TrapE && mlast};
         got_v = {forwardae, forwardbe, stallf, stalld, stalle, flushd, flushe, flushm,
                  mdu_busy, mdu_done};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL rand%0d_ctl: got %b expected %b", n, got_v, exp_v);
         end
`ifdef HAZARD_PERF_EN
         checks++;
         if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
            errors++;
            $display("FAIL rand%0d_cnt: got %0d/%0d expected %0d/%0d",
                     n, stall_cnt, flush_cnt, m_stall, m_flush);
         end
`endif
         if (rst) begin
            m_stall = 0; m_flush = 0;
         end else begin
            if (ctl[5]) m_stall = m_stall + 1;
            if (ctl[2:0] != 3'b000) m_flush = m_flush + 1;
         end
         if (rst || TrapE)              elapsed = 0;
         else if (elapsed == 0)         elapsed = MduStartE ? 1 : 0;
         else if (elapsed == int'(LAT) - 1) elapsed = 0;
         else                           elapsed = elapsed + 1;
         @(negedge clk);
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_priority();
      test_mdu_sequence();
      test_back_to_back();
      test_abort();
      test_perf();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor hazard unit for the 5-stage RISC-V core (F/D/E/M/W).
- Adds to M/W forwarding and load-use stalling:
  - a multi-cycle MDU (mul/div) stall FSM with counter,
  - use-qualified load-use detection,
  - a trap flush,
  - branch-over-stall priority, so a redirect is never lost.
- Sits beside the datapath and drives stall/flush enables of the F/D, D/E and E/M pipeline registers plus the E-stage forwarding muxes.

Parameters:
- REG_AW, 5, register address width.
- MDU_LAT, 4, E-stage occupancy in cycles of a mul/div op; legal range 2..16.
- CNT_W, 4, width of MDU countdown counter; must hold MDU_LAT-2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- rs1d, rs2d  in  REG_AW  source regs in D.
- UseRs1D, UseRs2D  in  1  D instruction actually reads rs1/rs2.
- rs1e, rs2e, rde  in  REG_AW  source/dest regs in E.
- rdm, rdw  in  REG_AW  dest regs in M/W.
- RegWriteM, RegWriteW  in  1  write enables in M/W.
- ResultSrcE, ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 IMM.
- PCsrc  in  1  taken branch/jump resolved in E.
- MduStartE  in  1  E instruction is mul/div; held while it sits in E.
- TrapE  in  1  exception/interrupt redirect.
- forwardae, forwardbe  out  2  00 RF, 01 W result, 10 M ALU result, 11 M PC+4/IMM.
- stallf, stalld, stalle  out  1  hold PC, F/D, D/E registers.
- flushd, flushe, flushm  out  1  bubble into D, E, M.
- mdu_busy  out  1  FSM in BUSY.
- mdu_done  out  1  one-cycle pulse on final MDU cycle.
- stall_cnt, flush_cnt  out  32  perf counters (see Optional Feature).

Behaviour:
- Forwarding, combinational. For X in {a:rs1e, b:rs2e}:
  - Match M: rsXe==rdm, RegWriteM, rsXe!=0, ResultSrcM!=01. Gives 11 if ResultSrcM[1], else 10.
  - Otherwise match W: rsXe==rdw, RegWriteW, rsXe!=0. Gives 01.
  - Otherwise 00.
  - M beats W.
  - An M match with ResultSrcM==01 falls through to W/RF; it is illegal given load-use stall, and the bench asserts it never occurs.
- ld_stall = ResultSrcE==01 && rde!=0 && ((UseRs1D && rs1d==rde) || (UseRs2D && rs2d==rde)).
- MDU FSM, states IDLE and BUSY, counter cnt.
  - IDLE & MduStartE: mdu_stall=1; next BUSY; cnt<=MDU_LAT-2.
  - BUSY & cnt!=0: mdu_stall=1; cnt<=cnt-1; MduStartE ignored.
  - BUSY & cnt==0: mdu_stall=0; mdu_done=1; next IDLE.
  - A back-to-back mul entering E next cycle restarts from IDLE.
  - E occupancy is exactly MDU_LAT cycles: MDU_LAT-1 stall cycles.
- mdu_busy = (state==BUSY).
- Output priority, highest first:
  1. TrapE: flushd=flushe=flushm=1; all stalls 0; FSM forced IDLE, cnt=0. This aborts an in-flight MDU op; mdu_done is not pulsed.
  2. mdu_stall: stallf=stalld=stalle=1; flushm=1; flushd=flushe=0; PCsrc and ld_stall masked (E holds a non-branching mul).
  3. PCsrc: flushd=flushe=1; stallf=stalld=0, even if ld_stall, so the redirect is taken.
  4. ld_stall: stallf=stalld=1; flushe=1.
  5. Else all 0.
- Reset (rst=1 at clk edge): state IDLE, cnt 0, counters 0.
- While rst is high, outputs are forced as follows:
  - flushd=flushe=flushm=1, stalls 0, forwards 00;
  - mdu_busy=mdu_done=0.
- Reset mid-MDU op behaves as trap.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments each cycle stallf=1.
  - flush_cnt increments each cycle flushd|flushe|flushm=1.
  - Both are 32-bit, wrap at 2^32-1→0, cleared by rst, and not incremented while rst=1.
- Undefined: counters not built; both ports tied to 0.

Test Plan:
- rs1e=rs2e=5, rdm=5 RegWriteM=1 ResultSrcM=00, rdw=5 RegWriteW=1 -> forwardae=forwardbe=10. ResultSrcM=10 -> forwardae=forwardbe=11. rs1e=0 -> forwardae=00.
- ResultSrcE=01 rde=7, rs2d=7 UseRs2D=1 -> stallf=stalld=flushe=1. Same with UseRs2D=0 -> all 0.
- MDU_LAT=4, MduStartE high at cycle 0 -> stalls/flushm high cycles 0-2; mdu_done cycle 3; mdu_busy cycles 1-3; IDLE cycle 4.
- ld_stall and PCsrc together -> flushd=flushe=1, stallf=stalld=0.
- MDU BUSY with cnt=1, TrapE=1 -> flushd/e/m=1, stalls 0, next cycle mdu_busy=0, no mdu_done. Repeat with rst instead -> same.
- HAZARD_PERF_EN: 3 ld_stall cycles + 2 PCsrc cycles -> stall_cnt=3, flush_cnt=5. Preload to 32'hFFFFFFFF, one stall -> 0.
